// File: rtl/dfd_trace_network_mc.sv
// dfd_trace_network_mc: per-core ingress FIFOs feeding per-channel backpressure-aware round-robin arbiters and output pipelines
module dfd_trace_network_mc #(
    parameter int NUM_CORES           = 8,
    parameter int NUM_CHANNELS        = 2,
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
    parameter int FIFO_DEPTH          = 2,
    parameter int NUM_PIPE_STAGES     = 1,
    localparam int SLOTS              = NUM_CORES / NUM_CHANNELS
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [NUM_CORES-1:0]                      MS_TN_Vld,
    input  logic [NUM_CORES-1:0]                      MS_TN_Src,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]      MS_TN_Data,
    output logic [NUM_CORES-1:0]                      TN_MS_Gnt,
    output logic [NUM_CORES-1:0]                      TN_MS_Ntrace_Bp,
    output logic [NUM_CORES-1:0]                      TN_MS_Dst_Bp,
    output logic [NUM_CORES-1:0]                      TN_MS_Ntrace_Flush,
    output logic [NUM_CORES-1:0]                      TN_MS_Dst_Flush,
    output logic [NUM_CHANNELS-1:0][SLOTS-1:0]        TN_TR_Vld,
    output logic [NUM_CHANNELS-1:0]                   TN_TR_Src,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   TN_TR_Data,
    input  logic                                      TN_TR_Ntrace_Bp,
    input  logic                                      TN_TR_Dst_Bp,
    input  logic                                      TN_TR_Ntrace_Flush,
    input  logic                                      TN_TR_Dst_Flush,
    input  logic [NUM_CORES-1:0]                      TN_TR_Enabled_Srcs
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef logic [DATA_WIDTH:0] beat_t;

    beat_t                                     mem_q [NUM_CORES][FIFO_DEPTH];
    logic [PW-1:0]                             wp_q [NUM_CORES];
    logic [PW-1:0]                             rp_q [NUM_CORES];
    logic [CW-1:0]                             cnt_q [NUM_CORES];
    logic [NUM_CORES-1:0]                      en_q;
    logic [NUM_CORES-1:0]                      push;
    logic [NUM_CORES-1:0]                      pop;
    beat_t                                     head [NUM_CORES];
    logic [SW-1:0]                             rr_q [NUM_CHANNELS];
    logic [SW-1:0]                             rr_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                   win_vld;
    logic [SLOTS-1:0]                          win_oh [NUM_CHANNELS];
    beat_t                                     win_beat [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][SLOTS-1:0]        pv_q [NUM_PIPE_STAGES];
    logic [NUM_CHANNELS-1:0]                   ps_q [NUM_PIPE_STAGES];
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   pd_q [NUM_PIPE_STAGES];
    logic                                      bp_n_q, bp_d_q, fl_n_q, fl_d_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Grant from registered state only, so Vld never feeds back into Gnt
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            TN_MS_Gnt[c] = en_q[c] && cnt_q[c] != CW'(FIFO_DEPTH);
            push[c]      = MS_TN_Vld[c] & TN_MS_Gnt[c];
            head[c]      = mem_q[c][rp_q[c]];
        end
    end

    // Per-channel round-robin search from rr_q over slots whose head type is not backpressured
    always_comb begin
        int k;
        int c;
        k   = 0;
        c   = 0;
        pop = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            rr_d[ch]     = rr_q[ch];
            win_vld[ch]  = 1'b0;
            win_oh[ch]   = '0;
            win_beat[ch] = '0;
            for (int i = 0; i < SLOTS; i++) begin
                k = int'(rr_q[ch]) + i;
                k = k >= SLOTS ? k - SLOTS : k;
                c = k * NUM_CHANNELS + ch;
                if (!win_vld[ch] && en_q[c] && cnt_q[c] != '0 &&
                    !(head[c][DATA_WIDTH] ? TN_TR_Dst_Bp : TN_TR_Ntrace_Bp)) begin
                    win_vld[ch]   = 1'b1;
                    win_oh[ch][k] = 1'b1;
                    win_beat[ch]  = head[c];
                    pop[c]        = 1'b1;
                    rr_d[ch]      = k == SLOTS - 1 ? '0 : SW'(k + 1);
                end
            end
        end
    end

    // FIFO storage; written only on a handshake, so it needs no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CORES; c++)
            if (push[c]) mem_q[c][wp_q[c]] <= {MS_TN_Src[c], MS_TN_Data[c]};
    end

    // FIFO bookkeeping; a disabled core is purged ahead of any push or pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                cnt_q[c] <= '0;
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
            end
        end else begin
            en_q <= TN_TR_Enabled_Srcs;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (!en_q[c]) begin
                    cnt_q[c] <= '0;
                    wp_q[c]  <= '0;
                    rp_q[c]  <= '0;
                end else begin
                    if (push[c]) wp_q[c] <= nxt(wp_q[c]);
                    if (pop[c]) rp_q[c] <= nxt(rp_q[c]);
                    cnt_q[c] <= cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
                end
            end
        end
    end

    // Arbiter pointers advance past the last granted slot
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            rr_q[ch] <= !reset_n ? '0 : rr_d[ch];
    end

    // Stall-free output pipeline plus one-cycle copies of funnel backpressure and flush
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_PIPE_STAGES; s++) begin
                pv_q[s] <= '0;
                ps_q[s] <= '0;
                pd_q[s] <= '0;
            end
            bp_n_q <= 1'b0;
            bp_d_q <= 1'b0;
            fl_n_q <= 1'b0;
            fl_d_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                pv_q[0][ch] <= win_oh[ch];
                if (win_vld[ch]) begin
                    ps_q[0][ch] <= win_beat[ch][DATA_WIDTH];
                    pd_q[0][ch] <= win_beat[ch][DATA_WIDTH-1:0];
                end
            end
            for (int s = 1; s < NUM_PIPE_STAGES; s++) begin
                pv_q[s] <= pv_q[s-1];
                ps_q[s] <= ps_q[s-1];
                pd_q[s] <= pd_q[s-1];
            end
            bp_n_q <= TN_TR_Ntrace_Bp;
            bp_d_q <= TN_TR_Dst_Bp;
            fl_n_q <= TN_TR_Ntrace_Flush;
            fl_d_q <= TN_TR_Dst_Flush;
        end
    end

    assign TN_TR_Vld          = pv_q[NUM_PIPE_STAGES-1];
    assign TN_TR_Src          = ps_q[NUM_PIPE_STAGES-1];
    assign TN_TR_Data         = pd_q[NUM_PIPE_STAGES-1];
    assign TN_MS_Ntrace_Bp    = {NUM_CORES{bp_n_q}};
    assign TN_MS_Dst_Bp       = {NUM_CORES{bp_d_q}};
    assign TN_MS_Ntrace_Flush = {NUM_CORES{fl_n_q}};
    assign TN_MS_Dst_Flush    = {NUM_CORES{fl_d_q}};
endmodule

// File: tb/tb_dfd_trace_network_mc.sv
// tb_dfd_trace_network_mc: directed checks on the default two-channel network and a four-channel, three-stage variant
module tb_dfd_trace_network_mc;
    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    logic [7:0]            vld, src, en, gnt, mbn, mbd, mfn, mfd;
    logic [7:0][127:0]     data;
    logic                  bpn, bpd, fln, fld;
    logic [1:0][3:0]       tvld;
    logic [1:0]            tsrc;
    logic [1:0][127:0]     tdata;

    logic [7:0]            vld_b, src_b, en_b, gnt_b, mbn_b, mbd_b, mfn_b, mfd_b;
    logic [7:0][127:0]     data_b;
    logic [3:0][1:0]       tvld_b;
    logic [3:0]            tsrc_b;
    logic [3:0][127:0]     tdata_b;

    always #5 clk = ~clk;

    dfd_trace_network_mc dut_a (
        .clk(clk), .reset_n(reset_n),
        .MS_TN_Vld(vld), .MS_TN_Src(src), .MS_TN_Data(data),
        .TN_MS_Gnt(gnt), .TN_MS_Ntrace_Bp(mbn), .TN_MS_Dst_Bp(mbd),
        .TN_MS_Ntrace_Flush(mfn), .TN_MS_Dst_Flush(mfd),
        .TN_TR_Vld(tvld), .TN_TR_Src(tsrc), .TN_TR_Data(tdata),
        .TN_TR_Ntrace_Bp(bpn), .TN_TR_Dst_Bp(bpd),
        .TN_TR_Ntrace_Flush(fln), .TN_TR_Dst_Flush(fld),
        .TN_TR_Enabled_Srcs(en)
    );

    dfd_trace_network_mc #(.NUM_CORES(8), .NUM_CHANNELS(4), .NUM_PIPE_STAGES(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .MS_TN_Vld(vld_b), .MS_TN_Src(src_b), .MS_TN_Data(data_b),
        .TN_MS_Gnt(gnt_b), .TN_MS_Ntrace_Bp(mbn_b), .TN_MS_Dst_Bp(mbd_b),
        .TN_MS_Ntrace_Flush(mfn_b), .TN_MS_Dst_Flush(mfd_b),
        .TN_TR_Vld(tvld_b), .TN_TR_Src(tsrc_b), .TN_TR_Data(tdata_b),
        .TN_TR_Ntrace_Bp(1'b0), .TN_TR_Dst_Bp(1'b0),
        .TN_TR_Ntrace_Flush(1'b0), .TN_TR_Dst_Flush(1'b0),
        .TN_TR_Enabled_Srcs(en_b)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int hs;
        reset_n = 1'b0;
        vld = '0; src = '0; data = '0; en = 8'hFF;
        bpn = 1'b0; bpd = 1'b0; fln = 1'b0; fld = 1'b0;
        vld_b = '0; src_b = '0; data_b = '0; en_b = 8'hFF;
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_vld", tvld, 0);
        chk("rst_src", tsrc, 0);
        chk("rst_data0", tdata[0], 0);
        chk("rst_bp", {mbn, mbd, mfn, mfd}, 0);
        chk("rst_gnt_b", gnt_b, 0);
        reset_n = 1'b1;
        chk("gnt_pre", gnt, 0);
        step();
        chk("gnt_up", gnt, 8'hFF);

        bpn = 1'b1; fld = 1'b1;
        step();
        chk("fwd_bpn", mbn, 8'hFF);
        chk("fwd_fld", mfd, 8'hFF);
        chk("fwd_bpd", {mbd, mfn}, 0);
        bpn = 1'b0; fld = 1'b0;
        step();
        chk("fwd_clr", {mbn, mfd}, 0);

        // single beat from core 2 -> channel 0 slot 1
        vld[2] = 1'b1; src[2] = 1'b0; data[2] = {16{8'hA5}};
        step();
        vld = '0;
        chk("one_t1", tvld, 0);
        step();
        chk("one_vld0", tvld[0], 4'b0010);
        chk("one_data", tdata[0], {16{8'hA5}});
        chk("one_src", tsrc[0], 0);
        chk("one_ch1", tvld[1], 0);
        step();
        chk("one_idle", tvld, 0);

        // round-robin over cores 0,2,4,6
        do_reset();
        for (int c = 0; c < 8; c += 2) begin
            vld[c] = 1'b1;
            data[c] = 128'h100 + 128'(c);
        end
        hs = 0;
        for (int i = 0; i < 24; i++) begin
            if (i >= 8 && vld[0] && gnt[0]) hs++;
            step();
            if (i + 1 >= 2) begin
                chk("rr_vld", tvld[0], 4'b0001 << ((i - 1) % 4));
                chk("rr_data", tdata[0], 128'h100 + 128'(2 * ((i - 1) % 4)));
            end
        end
        chk("rr_rate", hs, 4);
        chk("rr_ch1", tvld[1], 0);
        vld = '0;

        // dst backpressure holds core 0 while core 2 drains
        do_reset();
        bpd = 1'b1;
        vld[0] = 1'b1; src[0] = 1'b1; data[0] = 128'hD0;
        vld[2] = 1'b1; src[2] = 1'b0; data[2] = 128'h11;
        step();
        chk("tbp_t1", tvld[0], 0);
        vld[0] = 1'b0; data[2] = 128'h22;
        step();
        chk("tbp_n1", tvld[0], 4'b0010);
        chk("tbp_d1", tdata[0], 128'h11);
        vld = '0;
        step();
        chk("tbp_n2", tvld[0], 4'b0010);
        chk("tbp_d2", tdata[0], 128'h22);
        step();
        chk("tbp_hold", tvld[0], 0);
        bpd = 1'b0;
        step();
        chk("tbp_rel", tvld[0], 4'b0001);
        chk("tbp_src", tsrc[0], 1);
        chk("tbp_dd", tdata[0], 128'hD0);
        step();
        chk("tbp_end", tvld[0], 0);

        // fifo full on core 1 -> channel 1 slot 0
        do_reset();
        bpn = 1'b1;
        vld[1] = 1'b1; data[1] = 128'hB0;
        chk("full_g0", gnt[1], 1);
        step();
        data[1] = 128'hB1;
        chk("full_g1", gnt[1], 1);
        step();
        chk("full_g2", gnt[1], 0);
        data[1] = 128'hBAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_hold", {gnt[1], tvld[1]}, 0);
        end
        vld = '0; bpn = 1'b0;
        step();
        chk("full_o0", tvld[1], 4'b0001);
        chk("full_b0", tdata[1], 128'hB0);
        chk("full_gr", gnt[1], 1);
        step();
        chk("full_o1", tvld[1], 4'b0001);
        chk("full_b1", tdata[1], 128'hB1);
        step();
        chk("full_end", tvld[1], 0);

        // disable purge on core 3 -> channel 1 slot 1
        do_reset();
        bpn = 1'b1;
        vld[3] = 1'b1; data[3] = 128'h31;
        step();
        data[3] = 128'h32;
        step();
        vld = '0;
        chk("pg_full", gnt[3], 0);
        en[3] = 1'b0;
        step();
        chk("pg_g1", gnt[3], 0);
        step();
        chk("pg_g2", gnt[3], 0);
        en[3] = 1'b1; bpn = 1'b0;
        step();
        chk("pg_gnt", gnt[3], 1);
        for (int i = 0; i < 4; i++) begin
            chk("pg_none", tvld[1], 0);
            step();
        end

        // four channels, three pipe stages: core 5 -> channel 1 slot 1
        do_reset();
        vld_b[5] = 1'b1; data_b[5] = 128'h55;
        step();
        vld_b = '0;
        step();
        step();
        chk("cfg_t3", tvld_b, 0);
        step();
        chk("cfg_vld", tvld_b, 8'h08);
        chk("cfg_data", tdata_b[1], 128'h55);
        step();
        chk("cfg_idle", tvld_b, 0);

        vld_b[5] = 1'b1; vld_b[0] = 1'b1; data_b[0] = 128'h77;
        for (int i = 0; i < 6; i++) step();
        chk("cfg_stream", tvld_b, 8'h09);
        reset_n = 1'b0;
        step();
        chk("mrst_vld", tvld_b, 0);
        chk("mrst_d0", tdata_b[0], 0);
        chk("mrst_d1", tdata_b[1], 0);
        chk("mrst_gnt", gnt_b, 0);
        reset_n = 1'b1;
        vld_b = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mrst_gone", tvld_b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
